ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and decoded M-extension op, then holds the pipeline through `busy` while it computes: `busy` drives the ID/EX `halt` and the upstream stall. It produces a 64-bit result with a one-cycle `done` pulse, which the EX result mux selects.

## Interface
Parameters:
- `XLEN`, 64: operand/result width; only 64 is supported.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: a valid M-op is in EX (EX valid & M-op decode); level signal, held for the whole operation by the stall.
- `funct3` in 3: M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `is_word` in 1: OP-32 form (MULW/DIVW/DIVUW/REMW/REMUW).
- `op_a` in 64: rs1 value after forwarding.
- `op_b` in 64: rs2 value after forwarding.
- `flush` in 1: abort the current operation (trap/redirect).
- `busy` out 1: stall request to ID/EX `halt` and the IF/ID stage.
- `done` out 1: `result` valid this cycle.
- `result` out 64: final value; holds its last value otherwise.

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - MUL: one shift-add iteration per cycle.
  - DIV: one restoring iteration per cycle.
  - DONE: sign fix-up, `done`=1.
- IDLE, `start`=1, no `flush`:
  - latch the magnitudes of `op_a`/`op_b`, the result-sign flags and the op.
  - load the iteration counter N: 64, or 32 if `is_word`.
  - go to MUL (funct3<4) or DIV.
- Word ops:
  - signed ops sign-extend the operands from bit 31; unsigned ops zero-extend.
  - `result` = sign-extension of bit 31 of the 32-bit answer.
- Signedness:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: only `op_a` signed.
  - MULHU/DIVU/REMU: unsigned.
  - MUL uses the low 64 bits of the product and needs no sign handling.
- MUL: 128-bit product register; each cycle adds the multiplicand if the multiplier LSB is 1, then shifts.
  - DONE negates the 128-bit product when exactly one sign flag is set.
  - DONE selects the low half for MUL/MULW and the high half otherwise.
- DIV: restoring division on magnitudes with a 65-bit partial remainder.
  - DONE negates the quotient if the operand signs differ.
  - DONE negates the remainder if the dividend sign is set.
- Special cases, decided in IDLE, go straight to DONE (no iterations):
  - divisor 0: quotient = all ones (-1 at the word width), remainder = dividend.
  - signed overflow (min / -1): quotient = dividend, remainder = 0.
- MUL/DIV → DONE when the counter reaches 0. DONE → IDLE unconditionally; `start` is ignored in DONE, because that instruction is retiring.
- `flush` in any state → IDLE next cycle; `done` is suppressed.
- `rst`: state IDLE, `result`=0, `done`=0, `busy`=0, counter=0.

## Timing
- Cycle 0 is the first cycle `start` is seen in IDLE.
- `busy` is combinational: `!flush & ((IDLE & start & !special) | MUL | DIV)`. This makes ID/EX hold in cycle 0 without a bubble.
- Normal op:
  - `busy` is high for cycles 0..N.
  - `done` is high in cycle N+1 with `busy` low, so ID/EX advances at that edge.
- Special-case divide: `busy` is low, and `done` is high in cycle 1. The stall is never asserted, so this case is only legal when the EX result mux waits on `done`. EX treats `start & !done` in IDLE as stall-free only for specials; this is flagged via `busy` staying low. Cycle 1 DONE carries the result.
- Back-to-back M-ops: the next `start` is seen in the cycle after DONE; there are no lost or duplicated starts.
- `flush` together with `start` in IDLE: the operation is not started.
- `rst` has priority over `flush`, and `flush` has priority over `start`.

## Structure
- Package `muldiv_pkg`:
  - funct3 localparams: `F3_MUL` through `F3_REMU`.
  - state enum: IDLE, MUL, DIV, DONE.
  - `XLEN`.
- One sub-module, `div_iter`: the combinational restoring step (partial remainder, divisor, quotient bit in → next remainder/quotient). Keep the multiply step inline.

## Test plan
- MUL 7×(-3) → `result`=0xFFFF_FFFF_FFFF_FFEB; `busy` high for 65 cycles, `done` in cycle 65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE; MULH(-1,-1) → 0; MULHSU(-1, 2) → 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 → -3; REM -7/2 → -1; DIVUW 0xFFFF_FFFF/2 → 0x7FFF_FFFF in 33 cycles.
- DIV 5/0 → -1 and REMU 5/0 → 5; DIV 0x8000_0000_0000_0000/-1 → the same value and REM → 0; all with `done` in cycle 1 and `busy` never high.
- `flush` in MUL iteration 10 → IDLE next cycle, no `done`; a new MUL 3×4 two cycles later → 12.
- `rst` asserted in DIV iteration 20 → all outputs 0 next cycle; back-to-back DIVU then MUL both complete correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and FSM state type for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN = 64;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_iter #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0]   part;
  logic [W-1:0] diff;
  logic         ge;

  // The partial remainder is one bit wider than the divisor; after a successful
  // subtract the result is below the divisor, so the low W bits are exact.
  always_comb begin
    part  = {rem_i, quo_i[W-1]};
    ge    = part >= {1'b0, dvsr_i};
    diff  = part[W-1:0] - dvsr_i;
    rem_o = ge ? diff : part[W-1:0];
    quo_o = {quo_i[W-2:0], ge};
  end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, sign fix-up in DONE.
module ex_muldiv #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  localparam int W  = XLEN;
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            word_q, word_d;
  logic            negp_q, negp_d, negq_q, negq_d, negr_q, negr_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [W-1:0]    res_q, res_d;

  // Operand decode
  logic            sgn_a, sgn_b, neg_a, neg_b, is_div, div0, ovf, special;
  logic [W-1:0]    ext_a, ext_b, mag_a, mag_b, min_val;

  always_comb begin
    sgn_a   = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sgn_b   = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    ext_a   = is_word ? {{H{sgn_a & op_a[H-1]}}, op_a[H-1:0]} : op_a;
    ext_b   = is_word ? {{H{sgn_b & op_b[H-1]}}, op_b[H-1:0]} : op_b;
    neg_a   = sgn_a & ext_a[W-1];
    neg_b   = sgn_b & ext_b[W-1];
    mag_a   = neg_a ? -ext_a : ext_a;
    mag_b   = neg_b ? -ext_b : ext_b;
    min_val = is_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    is_div  = funct3[2];
    div0    = ext_b == '0;
    ovf     = sgn_b & (ext_a == min_val) & (&ext_b);
    special = is_div & (div0 | ovf);
  end

  // Iteration datapaths
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod_nx;
  logic [W-1:0]    rem_nx, quo_nx;

  always_comb begin
    mul_sum = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
    prod_nx = {mul_sum, prod_q[W-1:1]};
  end

  div_iter #(.W(W)) u_div_iter (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_nx),
    .quo_o  (quo_nx)
  );

  // Sign fix-up; a word product sits H bits up after H right-shifting iterations
  logic [2*W-1:0]  prod_full, prod_fix;
  logic [W-1:0]    q_fix, r_fix, raw, fix;

  always_comb begin
    prod_full = word_q ? (prod_q >> H) : prod_q;
    prod_fix  = negp_q ? -prod_full : prod_full;
    q_fix     = negq_q ? -quo_q : quo_q;
    r_fix     = negr_q ? -rem_q : rem_q;
    if (f3_q[2])
      raw = f3_q[1] ? r_fix : q_fix;
    else
      raw = (f3_q == F3_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    fix = word_q ? {{H{raw[H-1]}}, raw[H-1:0]} : raw;
  end

  assign busy   = !flush & (((state_q == IDLE) & start & !special) |
                            (state_q == MUL) | (state_q == DIV));
  assign done   = (state_q == DONE) & !flush;
  assign result = done ? fix : res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    word_d  = word_q;
    negp_d  = negp_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        f3_d    = funct3;
        word_d  = is_word;
        negp_d  = neg_a ^ neg_b;
        negq_d  = neg_a ^ neg_b;
        negr_d  = neg_a;
        prod_d  = {{W{1'b0}}, mag_b};
        mcand_d = mag_a;
        quo_d   = is_word ? (mag_a << H) : mag_a;
        rem_d   = '0;
        dvsr_d  = mag_b;
        cnt_d   = is_word ? CW'(H) : CW'(W);
        state_d = is_div ? DIV : MUL;
        // Specials preload the final answer unsigned and skip the iterations
        if (special) begin
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          quo_d   = div0 ? '1 : ext_a;
          rem_d   = div0 ? ext_a : '0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        res_d   = fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      word_q  <= 1'b0;
      negp_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      word_q  <= word_d;
      negp_q  <= negp_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic model plus per-cycle busy/done/result compare.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, start, is_word, flush;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] result;

  ex_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .is_word(is_word),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk_en = 1'b0;
  logic        chk_busy = 1'b1;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [63:0] exp_result = '0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Architectural RV64M result from plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  q, rm;
    logic [31:0]  a32, b32, q32, r32;
    longint       sa, sb;
    int           sa32, sb32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (!f3[2]) begin
      if (w) begin
        r32 = a32 * b32;
        return {{32{r32[31]}}, r32};
      end
      ea = (f3 == 3'd1 || f3 == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
      eb = (f3 == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      return (f3 == 3'd0) ? p[63:0] : p[127:64];
    end
    if (w) begin
      if (b32 == 0) begin q32 = '1; r32 = a32; end
      else if (!f3[0] && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; r32 = '0; end
      else if (!f3[0]) begin sa32 = a32; sb32 = b32; q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      return f3[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 0) begin q = '1; rm = a; end
    else if (!f3[0] && a == MIN && b == ALL1) begin q = a; rm = '0; end
    else if (!f3[0]) begin sa = a; sb = b; q = sa / sb; rm = sa % sb; end
    else begin q = a / b; rm = a % b; end
    return f3[1] ? rm : q;
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    if (!f3[2]) return 1'b0;
    if (w) return (b[31:0] == 0) || (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    return (b == 0) || (!f3[0] && a == MIN && b == ALL1);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (chk_busy) chk("busy", {63'b0, busy}, {63'b0, exp_busy});
      chk("done", {63'b0, done}, {63'b0, exp_done});
      chk("result", result, exp_result);
    end
  end

  task automatic idle(input int n);
    start    = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // kill: cycle in which flush (or rst if use_rst) is raised; -1 for none
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit,
                       input int kill, input logic use_rst);
    logic [63:0] m;
    logic        sp;
    int          n, dc;
    m  = model(f3, w, a, b);
    sp = is_special(f3, w, a, b);
    n  = w ? 32 : 64;
    dc = sp ? 1 : n + 1;
    start = 1'b1; funct3 = f3; is_word = w; op_a = a; op_b = b;
    for (int c = 0; c <= dc; c++) begin
      if (c == kill) begin
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        chk_busy = !use_rst;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; start = 1'b0; chk_busy = 1'b1;
        if (use_rst) exp_result = '0;
        return;
      end
      exp_busy = !sp && (c <= n);
      exp_done = (c == dc);
      if (c == dc) exp_result = m;
      @(negedge clk);
      if (c == dc) chk("literal", result, lit);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; is_word = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    do_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, -1, 1'b0);
    do_op(3'd3, 1'b0, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, -1, 1'b0);
    do_op(3'd1, 1'b0, ALL1, ALL1, 64'd0, -1, 1'b0);
    do_op(3'd2, 1'b0, ALL1, 64'd2, ALL1, -1, 1'b0);
    do_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1, 1'b0);
    do_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, -1, 1'b0);
    do_op(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, -1, 1'b0);
    do_op(3'd4, 1'b0, 64'd5, 64'd0, ALL1, -1, 1'b0);
    do_op(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, -1, 1'b0);
    do_op(3'd4, 1'b0, MIN, ALL1, MIN, -1, 1'b0);
    do_op(3'd6, 1'b0, MIN, ALL1, 64'd0, -1, 1'b0);
    do_op(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, -1, 1'b0);
    do_op(3'd6, 1'b1, 64'hFFFF_FFF9, 64'd3, ALL1, -1, 1'b0);
    do_op(3'd0, 1'b1, 64'h8000_0000, 64'd2, 64'd0, -1, 1'b0);
    idle(1);

    // flush mid-multiply, then a fresh multiply two cycles later
    do_op(3'd0, 1'b0, 64'd123, 64'd456, 64'd0, 10, 1'b0);
    idle(2);
    do_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, -1, 1'b0);
    // flush together with start in IDLE: nothing starts
    do_op(3'd4, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0);
    idle(2);
    // reset mid-divide, then back-to-back DIVU and MULW
    do_op(3'd4, 1'b0, 64'd1000, 64'd7, 64'd0, 20, 1'b1);
    idle(1);
    do_op(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, -1, 1'b0);
    do_op(3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, -1, 1'b0);
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end
endmodule
